// File: rtl/chacha_stream_pkg.sv
// chacha_stream_pkg: shared state/mode encodings and default widths for the ChaCha stream front end.
package chacha_stream_pkg;
    localparam int DEF_WORD_W      = 32;
    localparam int DEF_BLOCK_WORDS = 16;
    localparam int DEF_KEY_WORDS   = 8;
    localparam int DEF_NONCE_WORDS = 2;
    localparam int DEF_CTR_WORDS   = 2;
    localparam logic ENCRYP = 1'b0;
    localparam logic DECRYP = 1'b1;
    typedef enum logic [1:0] {ST_START, ST_HDR, ST_DATA, ST_OUT} state_t;
    function automatic int imax(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/word_slot_writer.sv
// word_slot_writer: deposits word idx into slot SLOTS-1-idx of a wide register and tracks filled slots.
module word_slot_writer
    import chacha_stream_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int SLOTS  = DEF_BLOCK_WORDS,
    parameter int IDX_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wr,
    input  logic [IDX_W-1:0]        idx,
    input  logic [WORD_W-1:0]       data,
    output logic [SLOTS*WORD_W-1:0] q,
    output logic [SLOTS-1:0]        keep
);
    always_ff @(posedge clk)
        if (rst || clr) begin
            q    <= '0;
            keep <= '0;
        end else if (wr)
            for (int i = 0; i < SLOTS; i++)
                if (idx == IDX_W'(SLOTS - 1 - i)) begin
                    q[i*WORD_W +: WORD_W] <= data;
                    keep[i]               <= 1'b1;
                end
endmodule

// File: rtl/stream_block_assembler.sv
// stream_block_assembler: packs a word stream into cipher blocks, extracting a key/nonce/counter
// header first in decrypt mode; partial final blocks are zero padded with a word-keep mask.
module stream_block_assembler
    import chacha_stream_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int KEY_WORDS   = DEF_KEY_WORDS,
    parameter int NONCE_WORDS = DEF_NONCE_WORDS,
    parameter int CTR_WORDS   = DEF_CTR_WORDS
) (
    input  logic                          blk_asm_clk,
    input  logic                          blk_asm_reset,
    input  logic                          encryp_decryp,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WORD_W-1:0]             s_data,
    input  logic                          s_last,
    output logic [KEY_WORDS*WORD_W-1:0]   public_key,
    output logic [NONCE_WORDS*WORD_W-1:0] nonce,
    output logic [CTR_WORDS*WORD_W-1:0]   counter,
    output logic                          hdr_valid,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [BLOCK_WORDS*WORD_W-1:0] m_data,
    output logic [BLOCK_WORDS-1:0]        m_keep,
    output logic                          m_last,
    output logic                          hdr_err
);
    localparam int HDR_WORDS = KEY_WORDS + NONCE_WORDS + CTR_WORDS;
    localparam int IDX_W     = $clog2(imax(BLOCK_WORDS, HDR_WORDS) + 1);

    state_t             state, eff, nxt;
    logic [IDX_W-1:0]   idx;
    logic               mode, cur_mode, acc, hdr_wr, blk_wr, hdr_abort, hdr_done, blk_done, out_done;
    logic [HDR_WORDS*WORD_W-1:0] hdr_q;
    logic [HDR_WORDS-1:0]        hdr_keep_unused;

    // START is transparent: the word arriving there is handled as if already in HDR or DATA
    always_comb begin
        eff       = state == ST_START ? (encryp_decryp == DECRYP ? ST_HDR : ST_DATA) : state;
        cur_mode  = state == ST_START ? encryp_decryp : mode;
        acc       = s_valid && s_ready;
        hdr_wr    = acc && eff == ST_HDR && cur_mode == DECRYP;
        blk_wr    = acc && eff == ST_DATA;
        hdr_abort = hdr_wr && s_last;
        hdr_done  = hdr_wr && !s_last && idx == IDX_W'(HDR_WORDS - 1);
        blk_done  = blk_wr && (s_last || idx == IDX_W'(BLOCK_WORDS - 1));
        out_done  = state == ST_OUT && m_ready;
        nxt       = hdr_abort ? ST_START : hdr_done ? ST_DATA : blk_done ? ST_OUT :
                    out_done ? (m_last ? ST_START : ST_DATA) : acc ? eff : state;
    end

    always_ff @(posedge blk_asm_clk)
        if (blk_asm_reset) begin
            state     <= ST_START;
            idx       <= '0;
            mode      <= ENCRYP;
            s_ready   <= 1'b0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            hdr_valid <= 1'b0;
            hdr_err   <= 1'b0;
        end else begin
            state   <= nxt;
            s_ready <= nxt != ST_OUT;
            m_valid <= nxt == ST_OUT;
            hdr_err <= hdr_abort;
            idx     <= (hdr_abort || hdr_done || blk_done) ? '0 : acc ? idx + 1'b1 : idx;
            if (state == ST_START) mode <= encryp_decryp;
            if (hdr_done) hdr_valid <= 1'b1;
            else if (out_done && m_last) hdr_valid <= 1'b0;
            if (blk_done) m_last <= s_last;
            else if (out_done) m_last <= 1'b0;
        end

    word_slot_writer #(.WORD_W(WORD_W), .SLOTS(BLOCK_WORDS), .IDX_W(IDX_W)) u_block (
        .clk(blk_asm_clk), .rst(blk_asm_reset), .clr(out_done), .wr(blk_wr),
        .idx(idx), .data(s_data), .q(m_data), .keep(m_keep)
    );

    // header fields persist across messages, so only reset clears them
    word_slot_writer #(.WORD_W(WORD_W), .SLOTS(HDR_WORDS), .IDX_W(IDX_W)) u_header (
        .clk(blk_asm_clk), .rst(blk_asm_reset), .clr(1'b0), .wr(hdr_wr),
        .idx(idx), .data(s_data), .q(hdr_q), .keep(hdr_keep_unused)
    );

    assign public_key = hdr_q[HDR_WORDS*WORD_W-1 -: KEY_WORDS*WORD_W];
    assign nonce      = hdr_q[CTR_WORDS*WORD_W +: NONCE_WORDS*WORD_W];
    assign counter    = hdr_q[CTR_WORDS*WORD_W-1:0];
endmodule

// File: tb/tb_stream_block_assembler.sv
// tb_stream_block_assembler: randomized scenarios checked against a block-splitting model of the stream.
module tb_stream_block_assembler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, encryp_decryp, s_valid, s_ready, s_last, hdr_valid, m_valid, m_ready, m_last, hdr_err;
    logic [31:0]  s_data;
    logic [255:0] public_key;
    logic [63:0]  nonce, counter;
    logic [511:0] m_data;
    logic [15:0]  m_keep;

    int vectors = 0, miscompares = 0, cyc = 0, last_acc_cyc = 0, hdr_err_cnt = 0, ready_viol = 0, rdy_mode = 0;
    logic [511:0] cap_data[$];
    logic [15:0]  cap_keep[$];
    logic         cap_last[$];
    int           cap_cyc[$];

    stream_block_assembler dut (
        .blk_asm_clk(clk), .blk_asm_reset(rst), .encryp_decryp(encryp_decryp),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .public_key(public_key), .nonce(nonce), .counter(counter), .hdr_valid(hdr_valid),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep),
        .m_last(m_last), .hdr_err(hdr_err)
    );

    always @(negedge clk)
        m_ready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (s_valid && s_ready) last_acc_cyc = cyc;
        if (m_valid && m_ready) begin
            cap_data.push_back(m_data);
            cap_keep.push_back(m_keep);
            cap_last.push_back(m_last);
            cap_cyc.push_back(cyc);
        end
        if (hdr_err === 1'b1) hdr_err_cnt++;
        if (m_valid === 1'b1 && s_ready === 1'b1) ready_viol++;
    end

    // Reference model: data words split into 16-word blocks, first word in the top slot
    function automatic logic [511:0] exp_data(input logic [31:0] w[$], input int b);
        logic [511:0] r = '0;
        for (int j = 0; j < 16 && 16*b + j < w.size(); j++) r[511 - 32*j -: 32] = w[16*b + j];
        return r;
    endfunction

    function automatic logic [15:0] exp_keep(input int n, input int b);
        logic [15:0] k = '0;
        for (int j = 0; j < 16 && 16*b + j < n; j++) k[15 - j] = 1'b1;
        return k;
    endfunction

    function automatic logic [255:0] field(input logic [31:0] w[$], input int s, input int n);
        logic [255:0] r = '0;
        for (int j = 0; j < n; j++) r = (r << 32) | 256'(w[s + j]);
        return r;
    endfunction

    task automatic clear_cap();
        cap_data.delete(); cap_keep.delete(); cap_last.delete(); cap_cyc.delete();
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input logic md, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = l; encryp_decryp = md;
        while (s_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            vectors++; miscompares++;
            $display("FAIL send_word_timeout: s_ready=%b, required 1", s_ready);
        end
        @(posedge clk); @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_msg(input logic md, input logic [31:0] w[$], input int max_gap);
        for (int i = 0; i < w.size(); i++)
            send_word(w[i], i == w.size() - 1, i == 0 ? md : 1'($urandom), $urandom_range(0, max_gap));
    endtask

    task automatic wait_blocks(input int n);
        int t = 0;
        while (cap_data.size() < n && t < 500) begin @(negedge clk); t++; end
        vectors++;
        if (cap_data.size() < n) begin
            miscompares++;
            $display("FAIL wait_blocks: got %0d blocks, required %0d", cap_data.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; encryp_decryp = 1'b0; rdy_mode = 0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({s_ready, m_valid, hdr_valid, m_last, hdr_err} !== 5'b0) begin miscompares++;
            $display("FAIL reset_ctrl: {s_ready,m_valid,hdr_valid,m_last,hdr_err}=%b, required 00000",
                     {s_ready, m_valid, hdr_valid, m_last, hdr_err}); end
        vectors++;
        if (m_data !== '0 || m_keep !== '0) begin miscompares++;
            $display("FAIL reset_block: m_data=%h m_keep=%h, required 0", m_data, m_keep); end
        vectors++;
        if ({public_key, nonce, counter} !== '0) begin miscompares++;
            $display("FAIL reset_hdr: key=%h nonce=%h ctr=%h, required 0", public_key, nonce, counter); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release: s_ready=%b, required 1", s_ready); end
    endtask

    task automatic test_encrypt_full();
        logic [31:0] w[$];
        clear_cap(); rdy_mode = 1;
        for (int i = 1; i <= 16; i++) w.push_back(32'(i));
        send_msg(1'b0, w, 0);
        wait_blocks(1);
        if (cap_data.size() > 0) begin
            vectors++;
            if (cap_data[0][511:480] !== 32'h1 || cap_data[0][31:0] !== 32'h10 || cap_data[0] !== exp_data(w, 0)) begin
                miscompares++; $display("FAIL enc_full_data: got %h, required %h", cap_data[0], exp_data(w, 0)); end
            vectors++;
            if (cap_keep[0] !== 16'hFFFF || cap_last[0] !== 1'b1) begin miscompares++;
                $display("FAIL enc_full_keep_last: keep=%h last=%b, required FFFF 1", cap_keep[0], cap_last[0]); end
            vectors++;
            if (cap_cyc[0] != last_acc_cyc + 1) begin miscompares++;
                $display("FAIL enc_full_latency: block at cycle %0d, required %0d", cap_cyc[0], last_acc_cyc + 1); end
        end
    endtask

    task automatic test_decrypt();
        logic [31:0] h[$], w[$];
        clear_cap(); rdy_mode = 0;
        for (int i = 0; i < 8; i++) h.push_back(32'hA0 + 32'(i));
        h.push_back(32'hB0); h.push_back(32'hB1); h.push_back(32'hC0); h.push_back(32'hC1);
        for (int i = 0; i < 11; i++) send_word(h[i], 1'b0, i == 0 ? 1'b1 : 1'($urandom), 0);
        vectors++;
        if (hdr_valid !== 1'b0) begin miscompares++; $display("FAIL dec_hdr_early: hdr_valid=%b, required 0", hdr_valid); end
        send_word(h[11], 1'b0, 1'($urandom), 0);
        vectors++;
        if (hdr_valid !== 1'b1) begin miscompares++; $display("FAIL dec_hdr_valid: hdr_valid=%b, required 1", hdr_valid); end
        vectors++;
        if (public_key[255:224] !== 32'hA0 || public_key !== field(h, 0, 8) || nonce !== 64'hB0_0000_00B1
            || counter !== 64'hC0_0000_00C1) begin miscompares++;
            $display("FAIL dec_fields: key=%h nonce=%h ctr=%h, required key=%h nonce=%h ctr=%h",
                     public_key, nonce, counter, field(h, 0, 8), 64'hB0_0000_00B1, 64'hC0_0000_00C1); end
        for (int i = 0; i < 16; i++) w.push_back($urandom);
        for (int i = 0; i < 16; i++) send_word(w[i], i == 15, 1'($urandom), 0);
        vectors++;
        if (m_valid !== 1'b1 || hdr_valid !== 1'b1) begin miscompares++;
            $display("FAIL dec_out_hold: m_valid=%b hdr_valid=%b, required 1 1", m_valid, hdr_valid); end
        rdy_mode = 1;
        wait_blocks(1);
        vectors++;
        if (hdr_valid !== 1'b0) begin miscompares++; $display("FAIL dec_hdr_clear: hdr_valid=%b, required 0", hdr_valid); end
        if (cap_data.size() > 0) begin
            vectors++;
            if (cap_data[0] !== exp_data(w, 0) || cap_keep[0] !== 16'hFFFF || cap_last[0] !== 1'b1) begin miscompares++;
                $display("FAIL dec_block: data=%h keep=%h last=%b, required data=%h keep=FFFF last=1",
                         cap_data[0], cap_keep[0], cap_last[0], exp_data(w, 0)); end
        end
    endtask

    task automatic test_partial();
        logic [31:0] w[$];
        clear_cap(); rdy_mode = 1;
        for (int i = 0; i < 5; i++) w.push_back($urandom | 32'h1);
        send_msg(1'b0, w, 1);
        wait_blocks(1);
        if (cap_data.size() > 0) begin
            vectors++;
            if (cap_keep[0] !== 16'hF800 || cap_last[0] !== 1'b1) begin miscompares++;
                $display("FAIL partial_keep_last: keep=%h last=%b, required F800 1", cap_keep[0], cap_last[0]); end
            vectors++;
            if (cap_data[0][351:0] !== '0 || cap_data[0] !== exp_data(w, 0)) begin miscompares++;
                $display("FAIL partial_data: got %h, required %h", cap_data[0], exp_data(w, 0)); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w[$];
        int stall_bad = 0;
        clear_cap(); rdy_mode = 0;
        for (int i = 0; i < 32; i++) w.push_back($urandom);
        fork
            send_msg(1'b0, w, 1);
            begin
                int t = 0;
                while (m_valid !== 1'b1 && t < 300) begin @(negedge clk); t++; end
                vectors++;
                if (t >= 300) begin miscompares++; $display("FAIL bp_first_block: m_valid=%b, required 1", m_valid); end
                repeat (10) begin
                    @(negedge clk);
                    if (s_ready !== 1'b0 || m_valid !== 1'b1) stall_bad++;
                end
                vectors++;
                if (stall_bad != 0) begin miscompares++;
                    $display("FAIL bp_stall: %0d stalled cycles with s_ready=1 or m_valid=0, required 0", stall_bad); end
                rdy_mode = 1;
            end
        join
        wait_blocks(2);
        for (int b = 0; b < 2 && b < cap_data.size(); b++) begin
            vectors++;
            if (cap_data[b] !== exp_data(w, b) || cap_keep[b] !== 16'hFFFF || cap_last[b] !== (b == 1)) begin miscompares++;
                $display("FAIL bp_block%0d: data=%h keep=%h last=%b, required data=%h keep=FFFF last=%b",
                         b, cap_data[b], cap_keep[b], cap_last[b], exp_data(w, b), b == 1); end
        end
    endtask

    task automatic test_hdr_err();
        logic [31:0] h[$], w[$];
        int e0;
        clear_cap(); rdy_mode = 1; e0 = hdr_err_cnt;
        for (int i = 0; i < 4; i++) h.push_back($urandom);
        send_msg(1'b1, h, 0);
        repeat (4) @(negedge clk);
        vectors++;
        if (hdr_err_cnt - e0 != 1 || cap_data.size() != 0 || hdr_valid !== 1'b0) begin miscompares++;
            $display("FAIL hdr_err: pulses=%0d blocks=%0d hdr_valid=%b, required 1 0 0",
                     hdr_err_cnt - e0, cap_data.size(), hdr_valid); end
        vectors++;
        if (public_key[255:160] !== {h[0], h[1], h[2]}) begin miscompares++;
            $display("FAIL hdr_err_partial: key_top=%h, required %h", public_key[255:160], {h[0], h[1], h[2]}); end
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        send_msg(1'b0, w, 0);
        wait_blocks(1);
        if (cap_data.size() > 0) begin
            vectors++;
            if (cap_data[0] !== exp_data(w, 0) || cap_keep[0] !== 16'hE000 || cap_last[0] !== 1'b1) begin miscompares++;
                $display("FAIL hdr_err_next: data=%h keep=%h last=%b, required data=%h keep=E000 last=1",
                         cap_data[0], cap_keep[0], cap_last[0], exp_data(w, 0)); end
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] w[$];
        clear_cap(); rdy_mode = 1;
        for (int i = 0; i < 7; i++) send_word(32'hDEAD_0000 | 32'(i + 1), 1'b0, 1'b0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({s_ready, m_valid, hdr_valid, m_last, hdr_err} !== 5'b0 || m_data !== '0 || m_keep !== '0 || public_key !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: ctrl=%b m_data=%h m_keep=%h key=%h, required all 0",
                     {s_ready, m_valid, hdr_valid, m_last, hdr_err}, m_data, m_keep, public_key); end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) w.push_back($urandom);
        send_msg(1'b0, w, 0);
        wait_blocks(1);
        repeat (3) @(negedge clk);
        vectors++;
        if (cap_data.size() != 1) begin miscompares++; $display("FAIL mid_reset_count: got %0d blocks, required 1", cap_data.size()); end
        if (cap_data.size() > 0) begin
            vectors++;
            if (cap_data[0] !== exp_data(w, 0) || cap_keep[0] !== 16'hFFFF || cap_last[0] !== 1'b1) begin miscompares++;
                $display("FAIL mid_reset_block: data=%h keep=%h last=%b, required data=%h keep=FFFF last=1",
                         cap_data[0], cap_keep[0], cap_last[0], exp_data(w, 0)); end
        end
    endtask

    task automatic test_random();
        for (int m = 0; m < 10; m++) begin
            logic [31:0] h[$], w[$], all[$];
            logic md;
            int nb;
            clear_cap(); rdy_mode = 2;
            md = 1'($urandom);
            if (md) for (int i = 0; i < 12; i++) h.push_back($urandom);
            for (int i = 0; i < $urandom_range(1, 40); i++) w.push_back($urandom);
            nb = (w.size() + 15) / 16;
            all = {h, w};
            send_msg(md, all, 2);
            wait_blocks(nb);
            repeat (3) @(negedge clk);
            vectors++;
            if (cap_data.size() != nb) begin miscompares++;
                $display("FAIL rand%0d_count: got %0d blocks, required %0d", m, cap_data.size(), nb); end
            for (int b = 0; b < nb && b < cap_data.size(); b++) begin
                vectors++;
                if (cap_data[b] !== exp_data(w, b) || cap_keep[b] !== exp_keep(w.size(), b) || cap_last[b] !== (b == nb - 1)) begin
                    miscompares++;
                    $display("FAIL rand%0d_block%0d: data=%h keep=%h last=%b, required data=%h keep=%h last=%b", m, b,
                             cap_data[b], cap_keep[b], cap_last[b], exp_data(w, b), exp_keep(w.size(), b), b == nb - 1);
                end
            end
            if (md) begin
                vectors++;
                if (public_key !== field(h, 0, 8) || nonce !== 64'(field(h, 8, 2)) || counter !== 64'(field(h, 10, 2))
                    || hdr_valid !== 1'b0) begin miscompares++;
                    $display("FAIL rand%0d_hdr: key=%h nonce=%h ctr=%h hdr_valid=%b, required key=%h nonce=%h ctr=%h hdr_valid=0",
                             m, public_key, nonce, counter, hdr_valid, field(h, 0, 8), 64'(field(h, 8, 2)), 64'(field(h, 10, 2)));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_encrypt_full();
        test_decrypt();
        test_partial();
        test_backpressure();
        test_hdr_err();
        test_reset_midstream();
        test_random();
        vectors++;
        if (ready_viol != 0) begin miscompares++;
            $display("FAIL ready_in_out: %0d cycles with s_ready and m_valid both high, required 0", ready_viol); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stream_block_assembler.md
Name: stream_block_assembler

Overview:
Parametrised successor to the 32-bit chunk integrator. Packs a word stream into fixed-size cipher blocks for the ChaCha core. In decrypt mode it first extracts a per-message header (key, nonce, counter). Adds output backpressure, message framing via s_last, and zero-padded partial final blocks with a word-keep mask. Sits between the AXI-Stream DMA input and the cipher core on the PYNQ-Z2 datapath.

Parameters:
WORD_W, 32, input word width in bits
BLOCK_WORDS, 16, words per output block (block = BLOCK_WORDS*WORD_W bits)
KEY_WORDS, 8, header key words (decrypt only)
NONCE_WORDS, 2, header nonce words
CTR_WORDS, 2, header counter words

Ports:
blk_asm_clk  in  1  clock
blk_asm_reset  in  1  synchronous, active-high reset
encryp_decryp  in  1  0 = encrypt (no header), 1 = decrypt (header first); sampled at message start only
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid & s_ready
s_data  in  WORD_W  input word
s_last  in  1  marks final word of a message
public_key  out  KEY_WORDS*WORD_W  captured key
nonce  out  NONCE_WORDS*WORD_W  captured nonce
counter  out  CTR_WORDS*WORD_W  captured counter
hdr_valid  out  1  header complete for current message
m_valid  out  1  block valid
m_ready  in  1  downstream accepts block
m_data  out  BLOCK_WORDS*WORD_W  assembled block
m_keep  out  BLOCK_WORDS  per-word valid mask; bit i covers word i (MSW = bit BLOCK_WORDS-1)
m_last  out  1  block ends the message
hdr_err  out  1  one-cycle pulse: s_last seen during header

Behaviour:
- Reset: all outputs 0, s_ready 0 in reset, state = START, word index = 0, mode register = 0.
- Word order: the first word of any field or block lands in its most significant slot, then descends. Header fields fill in order key, nonce, counter.
- States:
  - START: same cycle as HDR or DATA. Latches encryp_decryp and goes to HDR if 1, DATA if 0. It is a combinational pass-through, so the first word is accepted in START.
  - HDR: accepts KEY_WORDS+NONCE_WORDS+CTR_WORDS words. After the last counter word, hdr_valid = 1 on the next cycle and the state becomes DATA. hdr_valid stays high until the message's final block handshake completes.
  - DATA: fills the block register; unfilled words are 0.
    - BLOCK_WORDS-th word accepted -> OUT; m_keep all ones; m_last = s_last of that word.
    - s_last on an earlier word -> OUT; m_keep has ones for the filled words only; m_last = 1.
  - OUT: m_valid = 1 and m_data/m_keep/m_last are stable; s_ready = 0.
    - On m_valid & m_ready: the block register clears.
    - If m_last: hdr_valid clears and the state returns to START.
    - Otherwise the state returns to DATA.
- s_ready = 1 in START/HDR/DATA, 0 in OUT.
- Latency: m_valid rises the cycle after the completing word is accepted. Minimum block period is BLOCK_WORDS+1 cycles.
- Header fields hold their value after message end until overwritten by the next decrypt header. They are not cleared between messages.
- Empty message (s_last on a header word, decrypt):
  - hdr_err pulses for one cycle; the state returns to START.
  - Partial header values remain but hdr_valid stays 0.
  - No block is emitted.
- encryp_decryp changes mid-message are ignored until the next START.
- An s_valid drop mid-block or mid-header stalls the fill; the index is held.
- Synchronous reset mid-operation discards the partial block and header; outputs return to reset values next cycle.
- Index counter width is $clog2(max(BLOCK_WORDS, header total)+1). Wrap only via explicit reload.

Decomposition:
- Shared package chacha_stream_pkg holds:
  - state encoding constants ST_START, ST_HDR, ST_DATA, ST_OUT
  - mode constants ENCRYP = 0, DECRYP = 1
  - default width parameters
- One natural sub-module: word_slot_writer. It is a descending-index word deposit into a wide register with a clear input and keep-mask generation, instantiated for the block and reused for the header fields.

Test Plan:
1. Encrypt, 16 words 0x00000001..0x00000010 with s_last on word 16, m_ready = 1 -> one block: m_data[511:480] = 0x1, m_data[31:0] = 0x10, m_keep = 0xFFFF, m_last = 1, m_valid one cycle after word 16.
2. Decrypt, 12 header words (key 0xA0..0xA7, nonce 0xB0..0xB1, counter 0xC0..0xC1), then 16 data words -> public_key[255:224] = 0xA0, nonce = {0xB0, 0xB1}, counter = {0xC0, 0xC1}, hdr_valid high from cycle after 0xC1 until block accepted, block correct.
3. Encrypt, 5 words with s_last on word 5 -> m_keep = 0xF800, m_data[351:0] = 0, m_last = 1.
4. Encrypt, 32 words, m_ready held 0 for 10 cycles on the first block -> s_ready = 0 during the stall, no words lost, second block correct, only the second block has m_last = 1.
5. Decrypt, s_last on header word 4 -> hdr_err pulse, no m_valid, hdr_valid = 0. A following encrypt message works normally.
6. Reset asserted after 7 data words -> all outputs 0. A subsequent 16-word message produces a block with no residue from the aborted data.
